// File: rtl/tl_fc_gate.sv
// tl_fc_gate: transmit flow-control gate that holds each TLP until the link partner's
// credit limits cover it, then forwards it beat-for-beat and charges the credits.
module tl_fc_gate #(
  parameter int HDR_W = 8,
  parameter int DAT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      s_data_i,
  input  logic             s_sop_i,
  input  logic             s_eop_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [63:0]      m_data_o,
  output logic             m_sop_o,
  output logic             m_eop_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [1:0]       m_class_o,
  input  logic             fc_init_done_i,
  input  logic [HDR_W-1:0] cl_ph_i,
  input  logic [HDR_W-1:0] cl_nph_i,
  input  logic [HDR_W-1:0] cl_cplh_i,
  input  logic [DAT_W-1:0] cl_pd_i,
  input  logic [DAT_W-1:0] cl_npd_i,
  input  logic [DAT_W-1:0] cl_cpld_i,
  output logic             blocked_o
);
  typedef enum logic [1:0] {IDLE, CHECK, FWD} state_t;
  state_t state;
  logic [1:0] cls, cls_n;
  logic [DAT_W-1:0] req_d, req_n, cl_d, dd;
  logic [HDR_W-1:0] cl_h, hd;
  logic [HDR_W-1:0] cc_h [3];
  logic [DAT_W-1:0] cc_d [3];
  logic [4:0] typ;
  logic [10:0] len_q;
  logic fwd, ok, rel, acc;
  always_comb begin
    typ = s_data_i[28:24];
    len_q = ({1'b0, s_data_i[9:0]} + 11'd3) >> 2;
    cls_n = (typ[4:3] == 2'b10) ? 2'b00 :
            (typ == 5'b00000 && s_data_i[30]) ? 2'b00 :
            (typ == 5'b01010) ? 2'b10 : 2'b01;
    req_n = !s_data_i[30] ? '0 :
            (s_data_i[9:0] == 10'd0) ? DAT_W'(256) : DAT_W'(len_q);
    cl_h = (cls == 2'b00) ? cl_ph_i : (cls == 2'b01) ? cl_nph_i : cl_cplh_i;
    cl_d = (cls == 2'b00) ? cl_pd_i : (cls == 2'b01) ? cl_npd_i : cl_cpld_i;
    // modular distance to the limit must stay within half the counter range
    hd = cl_h - (cc_h[cls] + HDR_W'(1));
    dd = cl_d - (cc_d[cls] + req_d);
    ok = fc_init_done_i && hd <= {1'b1, {(HDR_W-1){1'b0}}} && dd <= {1'b1, {(DAT_W-1){1'b0}}};
    fwd = state == FWD;
    rel = state == CHECK && ok;
    acc = fwd && s_valid_i && m_ready_i;
    blocked_o = state == CHECK && !ok;
    s_ready_o = fwd && m_ready_i;
    m_valid_o = fwd && s_valid_i;
    m_data_o = fwd ? s_data_i : '0;
    m_sop_o = fwd && s_sop_i;
    m_eop_o = fwd && s_eop_i;
    m_class_o = cls;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cls <= 2'b00;
      req_d <= '0;
      cc_h <= '{default: '0};
      cc_d <= '{default: '0};
    end else begin
      if (state == IDLE && s_valid_i) begin
        state <= CHECK;
        cls <= cls_n;
        req_d <= req_n;
      end
      if (rel) begin
        state <= FWD;
        cc_h[cls] <= cc_h[cls] + HDR_W'(1);
        cc_d[cls] <= cc_d[cls] + req_d;
      end
      if (acc && s_eop_i) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_tl_fc_gate.sv
// tb_tl_fc_gate: directed bench for tl_fc_gate; an upstream beat queue feeds the gate
// and forwarded beats are compared against the pushed packet contents.
module tb_tl_fc_gate;
  localparam int HW = 8;
  localparam int DW = 12;
  logic clk = 0, rst = 1;
  logic [63:0] s_data_i, m_data_o;
  logic s_sop_i, s_eop_i, s_valid_i, s_ready_o;
  logic m_sop_o, m_eop_o, m_valid_o, m_ready_i, blocked_o, fc_init_done_i;
  logic [1:0] m_class_o;
  logic [HW-1:0] cl_ph_i, cl_nph_i, cl_cplh_i;
  logic [DW-1:0] cl_pd_i, cl_npd_i, cl_cpld_i;
  int n_chk = 0, n_fail = 0, pk = 0, stalls = 0;
  logic [65:0] up [$];
  logic [63:0] got [$], exp_q [$];
  bit in_pkt = 0, ok;

  tl_fc_gate #(.HDR_W(HW), .DAT_W(DW)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_sop_i(s_sop_i), .s_eop_i(s_eop_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_sop_o(m_sop_o), .m_eop_o(m_eop_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_class_o(m_class_o), .fc_init_done_i(fc_init_done_i),
    .cl_ph_i(cl_ph_i), .cl_nph_i(cl_nph_i), .cl_cplh_i(cl_cplh_i),
    .cl_pd_i(cl_pd_i), .cl_npd_i(cl_npd_i), .cl_cpld_i(cl_cpld_i),
    .blocked_o(blocked_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    s_valid_i = up.size() > 0;
    {s_sop_i, s_eop_i, s_data_i} = (up.size() > 0) ? up[0] : 66'd0;
  endtask

  // sample the settled cycle, then advance to the next negedge and present new inputs
  task automatic cyc();
    if (s_valid_i && !in_pkt)
      assert (s_sop_i) else $error("FAIL protocol: packet start beat without SOP");
    if (m_valid_o && m_ready_i) got.push_back(m_data_o);
    if (s_valid_i && s_ready_o) begin
      in_pkt = !up[0][64];
      void'(up.pop_front());
    end
    @(negedge clk);
    drive();
    #1;
  endtask

  task automatic push_pkt(logic [31:0] dw0, int n);
    logic [63:0] d;
    for (int b = 0; b < n; b++) begin
      d = {24'(pk), 8'(b), (b == 0) ? dw0 : 32'(b)};
      up.push_back({b == 0, b == n - 1, d});
      exp_q.push_back(d);
    end
    pk++;
    drive();
    #1;
  endtask

  task automatic run(int budget, output bit done);
    for (int k = 0; k < budget && up.size() > 0; k++) cyc();
    done = up.size() == 0;
  endtask

  task automatic cmp_beats(string tag);
    chk({tag, "_n"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk(tag, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  task automatic reset_dut();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    up.delete();
    in_pkt = 0;
    got.delete();
    exp_q.delete();
    drive();
    #1;
  endtask

  initial begin
    {cl_ph_i, cl_nph_i, cl_cplh_i} = '0;
    {cl_pd_i, cl_npd_i, cl_cpld_i} = '0;
    fc_init_done_i = 1;
    m_ready_i = 1;
    @(negedge clk);
    drive();
    #1;
    reset_dut();
    chk("rst_ctl", 64'({s_ready_o, m_valid_o, m_sop_o, m_eop_o, blocked_o}), 64'd0);
    chk("rst_class", 64'(m_class_o), 64'd0);
    chk("rst_data", m_data_o, 64'd0);

    // posted MWr len=8 needs 1 header + 2 data credits
    cl_ph_i = 1;
    cl_pd_i = 2;
    push_pkt(32'h4000_0008, 5);
    chk("t1_idle_rdy", 64'(s_ready_o), 64'd0);
    cyc();
    chk("t1_check_blk", 64'(blocked_o), 64'd0);
    cyc();
    chk("t1_fwd_rdy", 64'(s_ready_o), 64'd1);
    chk("t1_fwd_sop", 64'({m_valid_o, m_sop_o}), 64'd3);
    chk("t1_class", 64'(m_class_o), 64'd0);
    run(20, ok);
    chk("t1_done", 64'(ok), 64'd1);
    cmp_beats("t1_beat");

    // consumed PH=1, PD=2: same limits must now block a 1-credit MWr
    push_pkt(32'h4000_0001, 1);
    cyc();
    chk("t1b_blk", 64'(blocked_o), 64'd1);
    cyc();
    chk("t1b_hold", 64'({blocked_o, s_ready_o}), 64'd2);
    cl_ph_i = 2;
    cl_pd_i = 3;
    #1;
    chk("t1b_lim_seen", 64'(blocked_o), 64'd0);
    cyc();
    chk("t1b_rel", 64'(s_ready_o), 64'd1);
    run(5, ok);
    cmp_beats("t1b_beat");

    // non-posted MRd blocked on NPH
    push_pkt(32'h0000_0001, 1);
    cyc();
    chk("t2_blk", 64'(blocked_o), 64'd1);
    cyc();
    chk("t2_hold", 64'({blocked_o, s_ready_o}), 64'd2);
    cl_nph_i = 1;
    #1;
    chk("t2_lim", 64'(blocked_o), 64'd0);
    cyc();
    chk("t2_class", 64'(m_class_o), 64'd1);
    run(5, ok);
    cmp_beats("t2_beat");
    // CfgWr0 with one data credit: passes only if the MRd charged no data
    cl_nph_i = 2;
    cl_npd_i = 1;
    push_pkt(32'h4400_0001, 1);
    cyc();
    chk("t2_npd_zero", 64'(blocked_o), 64'd0);
    run(5, ok);
    cmp_beats("t2b_beat");

    // CplD len=0 needs 256 data credits
    cl_cplh_i = 1;
    cl_cpld_i = 255;
    push_pkt(32'h4A00_0000, 2);
    cyc();
    chk("t3_blk", 64'(blocked_o), 64'd1);
    cl_cpld_i = 256;
    #1;
    chk("t3_rel", 64'(blocked_o), 64'd0);
    cyc();
    chk("t3_class", 64'(m_class_o), 64'd2);
    run(5, ok);
    cmp_beats("t3_beat");
    cl_cplh_i = 2;
    push_pkt(32'h4A00_0004, 1);
    cyc();
    chk("t3_cc256_blk", 64'(blocked_o), 64'd1);
    cl_cpld_i = 257;
    #1;
    chk("t3_cc256_rel", 64'(blocked_o), 64'd0);
    run(5, ok);
    cmp_beats("t3b_beat");

    // flow-control init gate
    fc_init_done_i = 0;
    cl_ph_i = 10;
    cl_pd_i = 100;
    push_pkt(32'h4000_0001, 1);
    cyc();
    chk("t4_init_blk", 64'(blocked_o), 64'd1);
    cyc();
    chk("t4_init_rdy", 64'(s_ready_o), 64'd0);
    fc_init_done_i = 1;
    #1;
    chk("t4_init_rel", 64'(blocked_o), 64'd0);
    cyc();
    chk("t4_fwd", 64'(s_ready_o), 64'd1);
    run(5, ok);
    cmp_beats("t4_beat");

    // downstream ready toggling 1010 inside a packet
    cl_ph_i = 20;
    push_pkt(32'h4000_000C, 4);
    cyc();
    cyc();
    for (int k = 0; k < 8 && up.size() > 0; k++) begin
      m_ready_i = (k % 2) == 0;
      #1;
      chk("t5_mirror", 64'(s_ready_o), 64'(m_ready_i));
      cyc();
    end
    m_ready_i = 1;
    run(5, ok);
    chk("t5_done", 64'(ok), 64'd1);
    cmp_beats("t5_beat");

    // header counter wrap: 255 packets then the 256th with limit 0
    reset_dut();
    cl_pd_i = 2000;
    for (int i = 0; i < 255; i++) begin
      cl_ph_i = HW'(i + 1);
      push_pkt(32'h4000_0001, 1);
      run(5, ok);
      if (!ok) stalls++;
    end
    chk("t6_stalls", 64'(stalls), 64'd0);
    chk("t6_count", 64'(got.size()), 64'd255);
    got.delete();
    exp_q.delete();
    cl_ph_i = 0;
    push_pkt(32'h4000_0001, 1);
    cyc();
    chk("t6_wrap_rel", 64'(blocked_o), 64'd0);
    run(5, ok);
    push_pkt(32'h4000_0001, 1);
    cyc();
    chk("t6_wrap_blk", 64'(blocked_o), 64'd1);
    cl_ph_i = 1;
    run(5, ok);
    chk("t6_wrap_done", 64'(ok), 64'd1);
    cmp_beats("t6_beat");

    // reset mid-packet
    cl_ph_i = 10;
    push_pkt(32'h4000_000C, 6);
    cyc();
    cyc();
    chk("t7_fwd", 64'(m_valid_o), 64'd1);
    cyc();
    cyc();
    rst = 1;
    cyc();
    chk("t7_rst_ctl", 64'({s_ready_o, m_valid_o, m_sop_o, m_eop_o, blocked_o}), 64'd0);
    chk("t7_rst_data", m_data_o, 64'd0);
    chk("t7_rst_class", 64'(m_class_o), 64'd0);
    rst = 0;
    up.delete();
    in_pkt = 0;
    got.delete();
    exp_q.delete();
    drive();
    #1;
    cl_ph_i = 1;
    cl_pd_i = 1;
    push_pkt(32'h4000_0001, 1);
    cyc();
    chk("t7_cc_zero", 64'(blocked_o), 64'd0);
    run(5, ok);
    cmp_beats("t7_beat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
